// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU arbiter slice:
//   - ALU_W / RES_W : operand and result widths of the shared ALU
//   - op_e          : 3-bit ALU opcode encoding
//   - state_e       : arbiter FSM state encoding
//   - op_has_carry  : true for the opcodes whose carry output is meaningful
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_W = 8;
  localparam int RES_W = 16;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_MUL  = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_NAND = 3'b101,
    OP_NOR  = 3'b110,
    OP_XOR  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // The ALU holds its last carry for non-arithmetic ops; only add/sub
  // produce a carry/borrow worth forwarding.
  function automatic logic op_has_carry(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin picker. Searches req upward starting at ptr,
// wrapping modulo NREQ, and returns the first set bit.
// Ports:
//   req   in  NREQ  request bits
//   ptr   in  ID_W  highest-priority index this cycle (always < NREQ)
//   gnt   out NREQ  one-hot grant (all zero when no request)
//   idx   out ID_W  binary index of the grant (0 when no request)
//   any   out 1     at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  int w_cand;

  always_comb begin
    gnt    = '0;
    idx    = '0;
    any    = 1'b0;
    w_cand = 0;
    // Walk the NREQ candidates in priority order; the first hit wins.
    for (int k = 0; k < NREQ; k++) begin
      w_cand = (int'(ptr) + k) % NREQ;
      if (!any && req[w_cand]) begin
        any         = 1'b1;
        gnt[w_cand] = 1'b1;
        idx         = ID_W'(w_cand);
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational 8x8 ALU between NREQ requesters. Requests are
// accepted round-robin through a valid/ready handshake, operands are driven
// to the ALU from registers, the result is captured after one settle cycle
// and returned on a single response channel tagged with the requester ID.
//
// Optional feature (macro ALU_ARBITER_LOCK_EN):
//   adds req_lock[NREQ-1:0]; a granted requester with lock high keeps
//   priority for the next arbitration (atomic back-to-back sequences).
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/op/a/b      per-requester request, packed 3/8/8 bits per lane
//   req_lock              (lock build only) per-requester priority hold
//   req_ready             one-hot accept strobe, only in IDLE
//   rsp_valid/ready       response handshake
//   rsp_id/r/c/z          response: requester index, result, carry, zero
//   alu_a/b/o             registered operands/opcode to the ALU
//   alu_r/c/z             ALU result, carry, zero
// -----------------------------------------------------------------------------
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [3*NREQ-1:0]     req_op,
  input  logic [ALU_W*NREQ-1:0] req_a,
  input  logic [ALU_W*NREQ-1:0] req_b,
`ifdef ALU_ARBITER_LOCK_EN
  input  logic [NREQ-1:0]       req_lock,
`endif
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [RES_W-1:0]      rsp_r,
  output logic                  rsp_c,
  output logic                  rsp_z,
  output logic [ALU_W-1:0]      alu_a,
  output logic [ALU_W-1:0]      alu_b,
  output logic [2:0]            alu_o,
  input  logic [RES_W-1:0]      alu_r,
  input  logic                  alu_c,
  input  logic                  alu_z
);

  state_e           r_state;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_gid;
  logic [ALU_W-1:0] r_alu_a;
  logic [ALU_W-1:0] r_alu_b;
  logic [2:0]       r_alu_o;
  logic             r_rsp_valid;
  logic [ID_W-1:0]  r_rsp_id;
  logic [RES_W-1:0] r_rsp_r;
  logic             r_rsp_c;
  logic             r_rsp_z;

  logic [NREQ-1:0]  w_gnt;
  logic [ID_W-1:0]  w_idx;
  logic             w_any;
  logic [ID_W-1:0]  w_ptr_nxt;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_rr (
    .req (req_valid),
    .ptr (r_ptr),
    .gnt (w_gnt),
    .idx (w_idx),
    .any (w_any)
  );

  // Pointer moves to the slot just past the winner, wrapping at NREQ.
  assign w_ptr_nxt = (w_idx == ID_W'(NREQ - 1)) ? '0 : w_idx + 1'b1;

  // Accept strobe is combinational so the handshake closes on this edge.
  assign req_ready = (r_state == IDLE) ? w_gnt : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_gid       <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_o     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_r     <= '0;
      r_rsp_c     <= 1'b0;
      r_rsp_z     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_alu_o <= req_op[int'(w_idx)*3 +: 3];
            r_alu_a <= req_a[int'(w_idx)*ALU_W +: ALU_W];
            r_alu_b <= req_b[int'(w_idx)*ALU_W +: ALU_W];
            r_gid   <= w_idx;
`ifdef ALU_ARBITER_LOCK_EN
            // A locked winner keeps top priority for the next round.
            if (req_lock[w_idx]) r_ptr <= w_idx;
            else                 r_ptr <= w_ptr_nxt;
`else
            r_ptr   <= w_ptr_nxt;
`endif
            r_state <= EXEC;
          end
        end
        EXEC: begin
          // Operands have had a full cycle to propagate through the ALU.
          r_rsp_r     <= alu_r;
          r_rsp_z     <= alu_z;
          r_rsp_c     <= op_has_carry(r_alu_o) ? alu_c : 1'b0;
          r_rsp_id    <= r_gid;
          r_rsp_valid <= 1'b1;
          r_state     <= RESP;
        end
        RESP: begin
          // Payload and ALU lines are left untouched; only valid drops.
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_o     = r_alu_o;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_r     = r_rsp_r;
  assign rsp_c     = r_rsp_c;
  assign rsp_z     = r_rsp_z;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  localparam int NREQ = 2;
  localparam int ID_W = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [3*NREQ-1:0] req_op;
  logic [8*NREQ-1:0] req_a, req_b;
  logic [NREQ-1:0]   req_lock;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid, rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [15:0]       rsp_r;
  logic              rsp_c, rsp_z;
  logic [7:0]        alu_a, alu_b;
  logic [2:0]        alu_o;
  logic [15:0]       alu_r;
  logic              alu_c, alu_z;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
`ifdef ALU_ARBITER_LOCK_EN
    .req_lock(req_lock),
`endif
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_r(rsp_r), .rsp_c(rsp_c), .rsp_z(rsp_z),
    .alu_a(alu_a), .alu_b(alu_b), .alu_o(alu_o),
    .alu_r(alu_r), .alu_c(alu_c), .alu_z(alu_z)
  );

  // Environment ALU: combinational, carry holds its last add/sub value for
  // all other opcodes (the stale carry the arbiter must mask).
  logic       alu_hold = 1'b0;
  logic [8:0] alu_sum, alu_dif;
  always_comb begin
    alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
    alu_dif = {1'b0, alu_a} - {1'b0, alu_b};
    alu_c   = alu_hold;
    case (alu_o)
      3'd0: begin alu_r = {7'd0, alu_sum}; alu_c = alu_sum[8]; end
      3'd1: begin alu_r = {{8{alu_dif[8]}}, alu_dif[7:0]}; alu_c = alu_dif[8]; end
      3'd2: alu_r = alu_a * alu_b;
      3'd3: alu_r = {8'd0, alu_a & alu_b};
      3'd4: alu_r = {8'd0, alu_a | alu_b};
      3'd5: alu_r = {8'd0, ~(alu_a & alu_b)};
      3'd6: alu_r = {8'd0, ~(alu_a | alu_b)};
      default: alu_r = {8'd0, alu_a ^ alu_b};
    endcase
    alu_z = (alu_r == 16'd0);
  end
  always @(posedge clk) if (alu_o == 3'd0 || alu_o == 3'd1) alu_hold <= alu_c;

  // ---------------- reference model ----------------
  int m_ptr;

  function automatic int ref_pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  // Result from the opcode definitions with plain integer arithmetic.
  task automatic ref_alu(input int op, input int a, input int b,
                         output logic [15:0] r, output logic c, output logic z);
    int v;
    c = 1'b0;
    case (op)
      0: begin v = a + b; c = (v > 255); end
      1: begin v = a - b; c = (v < 0);   end
      2: v = a * b;
      3: v = a & b;
      4: v = a | b;
      5: v = 255 - (a & b);
      6: v = 255 - (a | b);
      default: v = a ^ b;
    endcase
    r = v[15:0];
    z = (r == 16'd0);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    req_op[i*3 +: 3] = op;
    req_a[i*8 +: 8]  = a;
    req_b[i*8 +: 8]  = b;
  endtask

  task automatic do_reset;
    rst = 1'b1; req_valid = '0; req_lock = '0; rsp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0;
    tick; tick;
    rst = 1'b0;
    m_ptr = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    do_reset;
    total++;
    if ({rsp_valid, rsp_id, rsp_r, rsp_c, rsp_z, alu_a, alu_b, alu_o, req_ready} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got v=%b id=%h r=%h c=%b z=%b a=%h b=%h o=%h rdy=%b want all zero",
               rsp_valid, rsp_id, rsp_r, rsp_c, rsp_z, alu_a, alu_b, alu_o, req_ready);
    end
  endtask

  task automatic test_alternate;
    logic [NREQ-1:0] exp_gnt;
    set_req(0, 3'd1, 8'h05, 8'h05);
    set_req(1, 3'd3, 8'hF0, 8'h0F);
    req_valid = 2'b11; rsp_ready = 1'b0;
    for (int n = 0; n < 4; n++) begin
      #1;
      exp_gnt = (n % 2 == 0) ? 2'b01 : 2'b10;
      total++;
      if (req_ready !== exp_gnt) begin bad++; $display("FAIL alt_grant%0d got %b want %b", n, req_ready, exp_gnt); end
      tick; tick;
      total++;
      if ({rsp_valid, rsp_r, rsp_z, rsp_c, rsp_id} !== {1'b1, 16'h0000, 1'b1, 1'b0, ID_W'(n % 2)}) begin
        bad++;
        $display("FAIL alt_rsp%0d got v=%b r=%h z=%b c=%b id=%h want v=1 r=0000 z=1 c=0 id=%0d",
                 n, rsp_valid, rsp_r, rsp_z, rsp_c, rsp_id, n % 2);
      end
      rsp_ready = 1'b1; tick; rsp_ready = 1'b0;
    end
    req_valid = '0;
  endtask

  task automatic test_single_add;
    set_req(0, 3'd0, 8'hFF, 8'h01);
    req_valid = 2'b01; rsp_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 2'b01) begin bad++; $display("FAIL add_ready got %b want 01", req_ready); end
    tick;
    req_valid = '0;
    total++;
    if ({req_ready, rsp_valid, alu_a, alu_b, alu_o} !== {2'b00, 1'b0, 8'hFF, 8'h01, 3'd0}) begin
      bad++;
      $display("FAIL add_exec got rdy=%b v=%b a=%h b=%h o=%h want rdy=00 v=0 a=ff b=01 o=0",
               req_ready, rsp_valid, alu_a, alu_b, alu_o);
    end
    tick;
    total++;
    if ({rsp_valid, rsp_r, rsp_c, rsp_z, rsp_id} !== {1'b1, 16'h0100, 1'b1, 1'b0, ID_W'(0)}) begin
      bad++;
      $display("FAIL add_rsp got v=%b r=%h c=%b z=%b id=%h want v=1 r=0100 c=1 z=0 id=0",
               rsp_valid, rsp_r, rsp_c, rsp_z, rsp_id);
    end
    tick;
    total++;
    if ({rsp_valid, rsp_r} !== {1'b0, 16'h0100}) begin
      bad++; $display("FAIL add_consumed got v=%b r=%h want v=0 r=0100", rsp_valid, rsp_r);
    end
  endtask

  task automatic test_backpressure;
    // pointer is at 1 after the req0 add
    set_req(1, 3'd2, 8'hFF, 8'hFF);
    set_req(0, 3'd4, 8'h12, 8'h34);
    req_valid = 2'b10; rsp_ready = 1'b0;
    #1;
    total++;
    if (req_ready !== 2'b10) begin bad++; $display("FAIL bp_ready got %b want 10", req_ready); end
    tick;
    req_valid = 2'b11;
    tick;
    for (int n = 0; n < 5; n++) begin
      total++;
      if ({rsp_valid, rsp_r, rsp_c, rsp_id, req_ready, alu_a, alu_o} !==
          {1'b1, 16'hFE01, 1'b0, ID_W'(1), 2'b00, 8'hFF, 3'd2}) begin
        bad++;
        $display("FAIL bp_hold%0d got v=%b r=%h c=%b id=%h rdy=%b a=%h o=%h want v=1 r=fe01 c=0 id=1 rdy=00 a=ff o=2",
                 n, rsp_valid, rsp_r, rsp_c, rsp_id, req_ready, alu_a, alu_o);
      end
      tick;
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    total++;
    if ({rsp_valid, req_ready} !== {1'b0, 2'b01}) begin
      bad++; $display("FAIL bp_release got v=%b rdy=%b want v=0 rdy=01", rsp_valid, req_ready);
    end
    req_valid = '0;
    tick;
  endtask

  task automatic test_carry_mask;
    set_req(0, 3'd0, 8'h80, 8'h80);
    req_valid = 2'b01; rsp_ready = 1'b1;
    tick; req_valid = '0; tick;
    total++;
    if ({rsp_valid, rsp_r, rsp_c, rsp_z} !== {1'b1, 16'h0100, 1'b1, 1'b0}) begin
      bad++; $display("FAIL mask_add got v=%b r=%h c=%b z=%b want v=1 r=0100 c=1 z=0", rsp_valid, rsp_r, rsp_c, rsp_z);
    end
    tick;
    set_req(1, 3'd7, 8'h0F, 8'h0F);
    set_req(0, 3'd7, 8'h0F, 8'h0F);
    req_valid = 2'b11;
    tick; req_valid = '0; tick;
    total++;
    if ({rsp_valid, rsp_r, rsp_c, rsp_z} !== {1'b1, 16'h0000, 1'b0, 1'b1}) begin
      bad++; $display("FAIL mask_xor got v=%b r=%h c=%b z=%b want v=1 r=0000 c=0 z=1", rsp_valid, rsp_r, rsp_c, rsp_z);
    end
    tick;
  endtask

  task automatic test_reset_in_resp;
    do_reset;
    set_req(0, 3'd0, 8'h01, 8'h02);
    set_req(1, 3'd0, 8'h03, 8'h04);
    req_valid = 2'b01; rsp_ready = 1'b0;
    tick; req_valid = '0; tick;   // now in RESP, pointer = 1
    rst = 1'b1; tick; rst = 1'b0;
    total++;
    if ({rsp_valid, rsp_id, rsp_r, rsp_c, rsp_z, alu_a, alu_b, alu_o} !== '0) begin
      bad++;
      $display("FAIL rst_resp got v=%b id=%h r=%h c=%b z=%b a=%h b=%h o=%h want all zero",
               rsp_valid, rsp_id, rsp_r, rsp_c, rsp_z, alu_a, alu_b, alu_o);
    end
    req_valid = 2'b11;
    #1;
    total++;
    if (req_ready !== 2'b01) begin bad++; $display("FAIL rst_ptr got %b want 01", req_ready); end
    req_valid = '0;
    m_ptr = 0;
  endtask

`ifdef ALU_ARBITER_LOCK_EN
  task automatic test_lock;
    logic [NREQ-1:0] exp_gnt;
    do_reset;
    set_req(0, 3'd0, 8'h01, 8'h01);
    set_req(1, 3'd4, 8'h10, 8'h01);
    req_valid = 2'b01; rsp_ready = 1'b1;
    tick; req_valid = '0; tick; tick;   // pointer now 1
    req_valid = 2'b11;
    for (int n = 0; n < 4; n++) begin
      req_lock = (n < 2) ? 2'b10 : 2'b00;
      #1;
      exp_gnt = (n < 3) ? 2'b10 : 2'b01;
      total++;
      if (req_ready !== exp_gnt) begin bad++; $display("FAIL lock_grant%0d got %b want %b", n, req_ready, exp_gnt); end
      tick; tick; tick;
    end
    req_valid = '0; req_lock = '0;
    do_reset;
  endtask
`endif

  // Randomized traffic against a transaction-level model.
  task automatic test_random;
    int          stage;       // 0 free, 1 computing, 2 presenting
    int          g, m_id;
    logic [2:0]  m_op;
    logic [7:0]  m_a, m_b;
    logic [15:0] m_r;
    logic        m_c, m_z, have;
    logic [NREQ-1:0] exp_rdy;
    do_reset;
    stage = 0; have = 1'b0; m_id = 0; m_op = '0; m_a = '0; m_b = '0; m_r = '0; m_c = 1'b0; m_z = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      req_valid = NREQ'($urandom);
      req_op    = (3*NREQ)'($urandom);
      req_a     = (8*NREQ)'($urandom);
      req_b     = (8*NREQ)'($urandom);
      if ($urandom_range(0, 3) == 0) begin req_a[7:0] = req_b[7:0]; end
      req_lock  = NREQ'($urandom_range(0, 3) == 0 ? $urandom : 0);
      rsp_ready = ($urandom_range(0, 2) != 0);
      #1;
      g = (stage == 0) ? ref_pick(req_valid, m_ptr) : -1;
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      total++;
      if (req_ready !== exp_rdy) begin bad++; $display("FAIL rnd_ready c%0d got %b want %b", cyc, req_ready, exp_rdy); end
      total++;
      if (rsp_valid !== (stage == 2)) begin bad++; $display("FAIL rnd_valid c%0d got %b want %b", cyc, rsp_valid, stage == 2); end
      if (stage != 0) begin
        total++;
        if ({alu_o, alu_a, alu_b} !== {m_op, m_a, m_b}) begin
          bad++; $display("FAIL rnd_alu c%0d got o=%h a=%h b=%h want o=%h a=%h b=%h", cyc, alu_o, alu_a, alu_b, m_op, m_a, m_b);
        end
      end
      if (stage == 2 || (stage == 0 && have)) begin
        total++;
        if ({rsp_r, rsp_c, rsp_z, rsp_id} !== {m_r, m_c, m_z, ID_W'(m_id)}) begin
          bad++;
          $display("FAIL rnd_rsp c%0d got r=%h c=%b z=%b id=%h want r=%h c=%b z=%b id=%0d",
                   cyc, rsp_r, rsp_c, rsp_z, rsp_id, m_r, m_c, m_z, m_id);
        end
      end
      // advance the model across the coming edge
      case (stage)
        0: if (g >= 0) begin
             m_id = g; m_op = req_op[g*3 +: 3]; m_a = req_a[g*8 +: 8]; m_b = req_b[g*8 +: 8];
`ifdef ALU_ARBITER_LOCK_EN
             m_ptr = req_lock[g] ? g : (g + 1) % NREQ;
`else
             m_ptr = (g + 1) % NREQ;
`endif
             stage = 1;
           end
        1: begin ref_alu(int'(m_op), int'(m_a), int'(m_b), m_r, m_c, m_z); have = 1'b1; stage = 2; end
        default: if (rsp_ready) stage = 0;
      endcase
      tick;
    end
    req_valid = '0; rsp_ready = 1'b1;
    tick; tick; tick;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_lock = '0; rsp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0; m_ptr = 0;
    test_reset;
    test_alternate;
    test_single_add;
    test_backpressure;
    test_carry_mask;
    test_reset_in_resp;
`ifdef ALU_ARBITER_LOCK_EN
    test_lock;
`endif
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
